// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer.
// State encodings are visible on state_o for debug and display.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      PAUSE     = 3'd3,
      POINT     = 3'd4,
      GAME_OVER = 3'd5
   } state_e;

   localparam int SCREEN_X_LAST = 639;
   localparam int SCREEN_Y_LAST = 479;

endpackage

// File: rtl/pong_match_ctrl_btn_edge.sv
// Two-flop synchroniser plus rising-edge detect for a raw button.
// The pulse is high for one cycle, in the third cycle after the press.
module btn_edge (
   input  logic clk_in,
   input  logic i_rst,
   input  logic btn_i,
   output logic pulse_o
);

   logic [2:0] sh_q;

   always_ff @(posedge clk_in or negedge i_rst) begin
      if (!i_rst) sh_q <= '0;
      else        sh_q <= {sh_q[1:0], btn_i};
   end

   assign pulse_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer: serve timing, scoring, pause and game over.
// Every output is a register updated on the edge that sees its cause.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30
) (
   input  logic               clk_in,
   input  logic               i_rst,
   input  logic               frame_end,
   input  logic               start_btn,
   input  logic               pause_btn,
   input  logic               point_p1,
   input  logic               point_p2,
   output logic               ball_run,
   output logic               ball_recenter,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               game_over,
   output logic               winner,
   output logic [2:0]         state_o
);

   localparam int MAXF = (SERVE_FRAMES > POINT_FRAMES) ?
                         SERVE_FRAMES : POINT_FRAMES;
   localparam int FW = (MAXF < 2) ? 1 : $clog2(MAXF);
   localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
   localparam logic [FW-1:0] POINT_LAST = FW'(POINT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   function automatic logic [SCORE_W-1:0] sat_inc(
      input logic [SCORE_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

   logic start_p;
   logic pause_p;

   btn_edge u_start (
      .clk_in  (clk_in),
      .i_rst   (i_rst),
      .btn_i   (start_btn),
      .pulse_o (start_p)
   );

   btn_edge u_pause (
      .clk_in  (clk_in),
      .i_rst   (i_rst),
      .btn_i   (pause_btn),
      .pulse_o (pause_p)
   );

   logic [1:0] pt_q, pt_old_q, pt_rise;
   state_e state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
   logic dir_q, dir_d, win_q, win_d, rc_q, rc_d;
   logic run_q, go_q;

   assign pt_rise = pt_q & ~pt_old_q;

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      dir_d   = dir_q;
      win_d   = win_q;
      rc_d    = 1'b0;
      unique case (state_q)
         IDLE, GAME_OVER: begin
            if (start_p) begin
               s1_d    = '0;
               s2_d    = '0;
               dir_d   = 1'b0;
               fcnt_d  = '0;
               rc_d    = 1'b1;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (frame_end) begin
               if (fcnt_q == SERVE_LAST) begin
                  fcnt_d  = '0;
                  state_d = PLAY;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         PLAY: begin
            // a point outranks a pause arriving in the same cycle
            if (|pt_rise) begin
               state_d = POINT;
               fcnt_d  = '0;
               if (pt_rise == 2'b01) begin
                  s1_d  = sat_inc(s1_q);
                  dir_d = 1'b1;
               end else if (pt_rise == 2'b10) begin
                  s2_d  = sat_inc(s2_q);
                  dir_d = 1'b0;
               end
            end else if (pause_p) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (start_p)      state_d = IDLE;
            else if (pause_p) state_d = PLAY;
         end
         POINT: begin
            if (frame_end) begin
               if (fcnt_q == POINT_LAST) begin
                  fcnt_d = '0;
                  if (s1_q == WIN || s2_q == WIN) begin
                     state_d = GAME_OVER;
                     win_d   = (s2_q == WIN);
                  end else begin
                     rc_d    = 1'b1;
                     state_d = SERVE;
                  end
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= IDLE;
         fcnt_q   <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         dir_q    <= 1'b0;
         win_q    <= 1'b0;
         rc_q     <= 1'b0;
         run_q    <= 1'b0;
         go_q     <= 1'b0;
         pt_q     <= '0;
         pt_old_q <= '0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         dir_q    <= dir_d;
         win_q    <= win_d;
         rc_q     <= rc_d;
         run_q    <= (state_d == PLAY);
         go_q     <= (state_d == GAME_OVER);
         pt_q     <= {point_p2, point_p1};
         pt_old_q <= pt_q;
      end
   end

   assign state_o       = state_q;
   assign ball_run      = run_q;
   assign ball_recenter = rc_q;
   assign serve_dir     = dir_q;
   assign score1        = s1_q;
   assign score2        = s2_q;
   assign game_over     = go_q;
   assign winner        = win_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed match scenarios with randomized timing and point outcomes,
// checked against a transaction-level model of the match rules.
module tb_pong_match_ctrl;

   localparam int WIN = 7;
   localparam int SF  = 60;
   localparam int PF  = 30;
   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2;
   localparam int S_PAUSE = 3, S_POINT = 4, S_GO = 5;

   logic clk_in = 1'b0;
   logic i_rst = 1'b1;
   logic frame_end = 1'b0;
   logic start_btn = 1'b0;
   logic pause_btn = 1'b0;
   logic point_p1 = 1'b0;
   logic point_p2 = 1'b0;
   logic ball_run, ball_recenter, serve_dir;
   logic [3:0] score1, score2;
   logic game_over, winner;
   logic [2:0] state_o;

   pong_match_ctrl dut (
      .clk_in        (clk_in),
      .i_rst         (i_rst),
      .frame_end     (frame_end),
      .start_btn     (start_btn),
      .pause_btn     (pause_btn),
      .point_p1      (point_p1),
      .point_p2      (point_p2),
      .ball_run      (ball_run),
      .ball_recenter (ball_recenter),
      .serve_dir     (serve_dir),
      .score1        (score1),
      .score2        (score2),
      .game_over     (game_over),
      .winner        (winner),
      .state_o       (state_o)
   );

   always #5 clk_in = ~clk_in;

   int n_assert = 0;
   int n_fail = 0;
   int rc_cnt = 0;

   int m_state = S_IDLE;
   int m_s1 = 0;
   int m_s2 = 0;
   int m_dir = 0;
   int m_win = 0;

   always @(posedge clk_in) if (ball_recenter === 1'b1) rc_cnt++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string t);
      chk({t, ".state"}, 32'(state_o), 32'(m_state));
      chk({t, ".run"}, 32'(ball_run), 32'(m_state == S_PLAY));
      chk({t, ".s1"}, 32'(score1), 32'(m_s1));
      chk({t, ".s2"}, 32'(score2), 32'(m_s2));
      chk({t, ".dir"}, 32'(serve_dir), 32'(m_dir));
      chk({t, ".go"}, 32'(game_over), 32'(m_state == S_GO));
      if (m_state == S_GO) chk({t, ".winner"}, 32'(winner), 32'(m_win));
   endtask

   task automatic press(input bit is_pause);
      if (is_pause) pause_btn = 1'b1;
      else          start_btn = 1'b1;
      tick($urandom_range(4, 7));
      pause_btn = 1'b0;
      start_btn = 1'b0;
      tick(3);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         frame_end = 1'b1;
         tick(1);
         frame_end = 1'b0;
         tick($urandom_range(0, 3));
      end
   endtask

   task automatic serve_to_play();
      frames(SF - 1);
      tick(2);
      chk("serve.wait", 32'(state_o), 32'(S_SERVE));
      frames(1);
      tick(2);
      m_state = S_PLAY;
      check_all("play");
   endtask

   // who: 0 = player 1, 1 = player 2, 2 = both in the same cycle
   task automatic score_point(input int who);
      point_p1 = (who != 1);
      point_p2 = (who != 0);
      tick(4);
      if (who == 0) begin m_s1++; m_dir = 1; end
      if (who == 1) begin m_s2++; m_dir = 0; end
      m_state = S_POINT;
      check_all("point");
      tick(5);
      check_all("point.hold");
      point_p1 = 1'b0;
      point_p2 = 1'b0;
      tick(2);
      rc_cnt = 0;
      frames(PF - 1);
      tick(2);
      chk("point.wait", 32'(state_o), 32'(S_POINT));
      frames(1);
      tick(3);
      if (m_s1 == WIN || m_s2 == WIN) begin
         m_state = S_GO;
         m_win = (m_s2 == WIN) ? 1 : 0;
         chk("point.rc_go", 32'(rc_cnt), 32'd0);
      end else begin
         m_state = S_SERVE;
         chk("point.rc", 32'(rc_cnt), 32'd1);
      end
      check_all("after_point");
   endtask

   task automatic new_match();
      rc_cnt = 0;
      press(1'b0);
      m_state = S_SERVE;
      m_s1 = 0;
      m_s2 = 0;
      m_dir = 0;
      check_all("start");
      chk("start.rc", 32'(rc_cnt), 32'd1);
   endtask

   initial begin
      int who, r, guard;
      #2 i_rst = 1'b0;
      #1 check_all("reset");
      chk("reset.rc", 32'(ball_recenter), 32'd0);
      chk("reset.winner", 32'(winner), 32'd0);
      tick(2);
      i_rst = 1'b1;
      tick(2);
      check_all("idle");

      new_match();
      serve_to_play();

      score_point(0);
      serve_to_play();

      score_point(2);
      serve_to_play();

      press(1'b1);
      m_state = S_PAUSE;
      check_all("pause");
      point_p1 = 1'b1;
      point_p2 = 1'b1;
      tick(6);
      check_all("pause.point");
      point_p1 = 1'b0;
      point_p2 = 1'b0;
      tick(2);
      press(1'b1);
      m_state = S_PLAY;
      check_all("unpause");
      press(1'b1);
      m_state = S_PAUSE;
      check_all("pause2");
      press(1'b0);
      m_state = S_IDLE;
      check_all("abort");

      new_match();
      serve_to_play();
      guard = 0;
      while (m_state != S_GO && guard < 40) begin
         r = $urandom_range(0, 9);
         who = (r < 7) ? 1 : (r < 9) ? 0 : 2;
         score_point(who);
         if (m_state == S_SERVE) serve_to_play();
         guard++;
      end
      chk("match.done", 32'(m_state), 32'(S_GO));
      tick(5);
      check_all("gameover");
      new_match();
      chk("restart.go", 32'(game_over), 32'd0);
      serve_to_play();

      point_p2 = 1'b1;
      tick(4);
      m_s2++;
      m_dir = 0;
      m_state = S_POINT;
      check_all("pre_reset");
      #2 i_rst = 1'b0;
      #1;
      m_state = S_IDLE;
      m_s1 = 0;
      m_s2 = 0;
      m_dir = 0;
      check_all("async_reset");
      chk("async_reset.rc", 32'(ball_recenter), 32'd0);
      point_p2 = 1'b0;
      tick(2);
      i_rst = 1'b1;
      tick(3);
      check_all("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
